// File: rtl/mdu_opcodes_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Contents: funct3 operation encodings, FSM state type, iteration count
// and small decode helpers used by both the MDU and its bench.
package mdu_opcodes_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    localparam int MDU_ITERS = 32;
    localparam int MDU_CNT_W = $clog2(MDU_ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM.
    function automatic logic mdu_a_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV)  || (op == MDU_REM);
    endfunction

    // rs2 is interpreted as signed for MULH, DIV and REM.
    function automatic logic mdu_b_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step (combinational).
// Ports:
//   rem_i          current partial remainder (always < divisor)
//   dividend_bit_i next dividend bit shifted into the remainder
//   divisor_i      divisor magnitude
//   rem_o          partial remainder after this step
//   q_o            quotient bit produced by this step
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    // 33-bit partial remainder: the shifted value can exceed 32 bits.
    logic [XLEN:0]   partial;
    logic [XLEN-1:0] diff;

    assign partial = {rem_i, dividend_bit_i};
    // When the subtraction succeeds the result is below the divisor, so the
    // low XLEN bits of the difference are exact.
    assign diff    = partial[XLEN-1:0] - divisor_i;
    assign q_o     = (partial >= {1'b0, divisor_i});
    assign rem_o   = q_o ? diff : partial[XLEN-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Multiplies by shift-add and divides by restoring division, one bit per
// cycle over 32 CALC cycles; divide-by-zero and signed overflow finish
// directly from IDLE.
// Ports:
//   clk_i     core clock
//   rst_i     synchronous active-high reset
//   req_i     MDU instruction in execute, held with operands until valid_o
//   mdu_op_i  operation (instruction funct3)
//   a_i, b_i  rs1 / rs2 operands
//   stall_o   req_i && !valid_o, freezes the pipeline
//   valid_o   one-cycle pulse, result_o is the answer to the current request
//   result_o  result, held until the next completion
// Handshake: the core raises req_i with stable operands and keeps it high
// until the cycle valid_o is seen; dropping req_i during CALC aborts with no
// valid_o and no result update. Inputs are only sampled in IDLE.
module mdu_iterative
    import mdu_opcodes_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [2:0]      mdu_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [MDU_CNT_W-1:0] CNT_LAST = MDU_CNT_W'(MDU_ITERS - 1);
    localparam logic [XLEN-1:0]      INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t           state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [XLEN-1:0]      opb_q, opb_d;
    logic [XLEN-1:0]      hi_q, hi_d;
    logic [XLEN-1:0]      lo_q, lo_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      result_q, result_d;

    // Operand decode in IDLE
    logic            a_neg, b_neg, neg_in, overflow;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_neg    = mdu_a_signed(mdu_op_i) & a_i[XLEN-1];
    assign b_neg    = mdu_b_signed(mdu_op_i) & b_i[XLEN-1];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign overflow = (a_i == INT_MIN) && (b_i == '1);

    always_comb begin
        neg_in = 1'b0;
        case (mdu_op_i)
            MDU_MULH:   neg_in = a_neg ^ b_neg;
            MDU_MULHSU: neg_in = a_neg;
            MDU_DIV:    neg_in = a_neg ^ b_neg;
            MDU_REM:    neg_in = a_neg;
            default:    neg_in = 1'b0;
        endcase
    end

    // One iteration. hi/lo hold {product hi, multiplier} for multiply and
    // {remainder, dividend->quotient} for divide; opb holds the other operand.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] div_rem;
    logic            div_q;
    logic [XLEN-1:0] iter_hi, iter_lo;

    assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : '0)};

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i          (hi_q),
        .dividend_bit_i (lo_q[XLEN-1]),
        .divisor_i      (opb_q),
        .rem_o          (div_rem),
        .q_o            (div_q)
    );

    assign iter_hi = op_q[2] ? div_rem : mul_sum[XLEN:1];
    assign iter_lo = op_q[2] ? {lo_q[XLEN-2:0], div_q} : {mul_sum[0], lo_q[XLEN-1:1]};

    // Sign-corrected result from the final iteration's values
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix, final_res;

    assign prod      = {iter_hi, iter_lo};
    assign prod_fix  = neg_q ? -prod : prod;
    assign div_raw   = op_q[1] ? iter_hi : iter_lo;
    assign div_fix   = neg_q ? -div_raw : div_raw;
    assign final_res = op_q[2] ? div_fix :
                       ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    op_d  = mdu_op_i;
                    neg_d = neg_in;
                    opb_d = b_mag;
                    hi_d  = '0;
                    lo_d  = a_mag;
                    cnt_d = CNT_LAST;
                    if (mdu_op_i[2] && (b_i == '0)) begin
                        result_d = mdu_op_i[1] ? a_i : '1;
                        state_d  = DONE;
                    end else if (((mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM)) && overflow) begin
                        result_d = mdu_op_i[1] ? '0 : INT_MIN;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = iter_hi;
                    lo_d  = iter_lo;
                    cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
                    if (cnt_q == '0) begin
                        result_d = final_res;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign valid_o  = (state_q == DONE);
    assign stall_o  = req_i && !valid_o;
    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: operations with hand-computed results,
// latency and stall checks, special cases, abort, mid-operation reset and
// back-to-back requests.
module tb_mdu_iterative;
    import mdu_opcodes_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [2:0]  mdu_op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mdu_iterative dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .mdu_op_i (mdu_op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for valid_o, sampling 1ns after each rising edge. lat is the
    // number of edges waited (-1 if it never came); stall_ok drops if
    // stall_o was low in any cycle before valid_o.
    task automatic wait_valid(output int lat, output bit stall_ok);
        bit seen;
        seen     = 1'b0;
        stall_ok = 1'b1;
        lat      = 0;
        while (!seen && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (valid_o) seen = 1'b1;
            else if (!stall_o) stall_ok = 1'b0;
        end
        if (!seen) lat = -1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit stall_ok;
        mdu_op_i = op;
        a_i      = a;
        b_i      = b;
        req_i    = 1'b1;
        #1;
        check({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
        wait_valid(lat, stall_ok);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_stall_at_valid"}, 32'(stall_o), 32'd0);
        check({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
        req_i = 1'b0;
        @(posedge clk_i);
        #1;
        check({tag, "_valid_one_cycle"}, 32'(valid_o), 32'd0);
        check({tag, "_result_hold"}, result_o, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  stall_ok;
        rst_i    = 1'b1;
        req_i    = 1'b0;
        mdu_op_i = 3'b000;
        a_i      = '0;
        b_i      = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        check("reset_cnt", 32'(dut.cnt_q), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Multiply family
        run_op("mul_7_m3",     MDU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu_m1_m1",  MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_m1_m1",   MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu_m1_ff", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        // Divide family
        run_op("div_m7_2",     MDU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",     MDU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu_100_7",   MDU_DIVU,   32'd100,       32'd7,         32'd14,        33);
        run_op("remu_100_7",   MDU_REMU,   32'd100,       32'd7,         32'd2,         33);

        // Special cases finish in one cycle
        run_op("divu_by0",     MDU_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",      MDU_REM,    32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",      MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",      MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Give result_o a nonzero value before the abort
        run_op("divu_100_7b",  MDU_DIVU,   32'd100,       32'd7,         32'd14,        33);

        // Abort: drop req_i at cycle 10 of a DIV
        mdu_op_i = MDU_DIV;
        a_i      = 32'd1000;
        b_i      = 32'd3;
        req_i    = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        check("abort_c10_valid", 32'(valid_o), 32'd0);
        req_i = 1'b0;
        begin
            bit saw_valid;
            saw_valid = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk_i);
                #1;
                if (valid_o) saw_valid = 1'b1;
                if (i == 0) check("abort_state_idle", 32'(dut.state_q), 32'(IDLE));
            end
            check("abort_no_valid", 32'(saw_valid), 32'd0);
        end
        check("abort_result_kept", result_o, 32'd14);
        run_op("mul_3_4",      MDU_MUL,    32'd3,         32'd4,         32'd12,        33);

        // Reset at cycle 5 of a MUL
        mdu_op_i = MDU_MUL;
        a_i      = 32'd5;
        b_i      = 32'd5;
        req_i    = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        req_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_result", result_o, 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        check("midrst_cnt", 32'(dut.cnt_q), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Back-to-back: MUL 2*3 then DIVU 9/2 with req_i held high
        mdu_op_i = MDU_MUL;
        a_i      = 32'd2;
        b_i      = 32'd3;
        req_i    = 1'b1;
        #1;
        wait_valid(lat, stall_ok);
        check("b2b_first_cycle", lat, 32'd33);
        check("b2b_first_result", result_o, 32'd6);
        mdu_op_i = MDU_DIVU;
        a_i      = 32'd9;
        b_i      = 32'd2;
        begin
            int lat2;
            wait_valid(lat2, stall_ok);
            check("b2b_second_cycle", lat + lat2, 32'd67);
            check("b2b_second_stall", 32'(stall_ok), 32'd1);
        end
        check("b2b_second_result", result_o, 32'd4);
        req_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("b2b_end_valid", 32'(valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
